// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the memory stage: icodes, status codes and the
// handshake FSM state type.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } memState_t;

endpackage

// File: rtl/mem_addr_chk.sv
// Combinational legality check for one DATA_W-wide access: every byte must lie
// in [0, MEM_BYTES) and, optionally, the address must be naturally aligned.
module mem_addr_chk #(
  parameter int ADDR_W    = 64,
  parameter int NBYTES    = 8,
  parameter int MEM_BYTES = 8192,
  parameter bit ALIGN_CHK = 1'b1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              addrOk
);

  localparam int LSB_W = $clog2(NBYTES);

  logic [ADDR_W:0] endAddr;
  logic            inBounds;
  logic            aligned;

  // One extra bit so an access that wraps past 2^ADDR_W can never look legal.
  assign endAddr  = {1'b0, addr} + (ADDR_W+1)'(NBYTES);
  assign inBounds = endAddr <= (ADDR_W+1)'(MEM_BYTES);
  assign aligned  = !ALIGN_CHK || (addr[LSB_W-1:0] == '0);
  assign addrOk   = inBounds && aligned;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Y86-64 memory stage: decodes the access, checks it, runs a req/gnt/rvalid
// handshake with timeout and hands valM/stat to write-back over valid/ready.
//
// state  | meaning
// S_IDLE | waiting for an instruction from execute
// S_REQ  | mem_req held, waiting for mem_gnt
// S_WAIT | granted, waiting for mem_rvalid or timeout
// S_DONE | result presented to write-back until out_ready
module mem_stage_ctrl
  import y86_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = 8192,
  parameter bit ALIGN_CHK = 1'b1,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] valE,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valP,
  input  logic              instr_valid,
  input  logic              imem_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [ADDR_W-1:0] out_valE,
  output logic [DATA_W-1:0] valM,
  output logic [2:0]        stat
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  memState_t         state, stateNext;
  logic              halted, started;
  logic              isRead, isWrite, addrOk, needMem, accept;
  logic [ADDR_W-1:0] accAddr;
  logic [DATA_W-1:0] accData;
  logic [2:0]        inStat;
  logic              reqRead;
  logic [CNT_W-1:0]  toCnt;

  always_comb begin
    isRead  = 1'b0;
    isWrite = 1'b0;
    accAddr = valE;
    accData = valA;
    case (icode)
      IRMMOVQ, IPUSHQ: isWrite = 1'b1;
      IMRMOVQ:         isRead  = 1'b1;
      ICALL: begin
        isWrite = 1'b1;
        accData = valP;
      end
      IRET, IPOPQ: begin
        isRead  = 1'b1;
        accAddr = ADDR_W'(valA);
      end
      default: ;
    endcase
  end

  mem_addr_chk #(
    .ADDR_W   (ADDR_W),
    .NBYTES   (NBYTES),
    .MEM_BYTES(MEM_BYTES),
    .ALIGN_CHK(ALIGN_CHK)
  ) uAddrChk (
    .addr  (accAddr),
    .addrOk(addrOk)
  );

  always_comb begin
    if (imem_error)                         inStat = SADR;
    else if (!instr_valid)                  inStat = SINS;
    else if (icode == IHALT)                inStat = SHLT;
    else if ((isRead || isWrite) && !addrOk) inStat = SADR;
    else                                    inStat = SAOK;
  end

  assign needMem = (inStat == SAOK) && (isRead || isWrite);
  assign accept  = in_valid && in_ready;

  always_comb begin
    stateNext = state;
    mem_req   = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = started && !halted && !out_valid;
        if (accept) stateNext = needMem ? S_REQ : S_DONE;
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt)             stateNext = S_WAIT;
        else if (toCnt == '0)    stateNext = S_DONE;
      end
      S_WAIT: begin
        if (mem_rvalid)          stateNext = S_DONE;
        else if (toCnt == '0)    stateNext = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      started   <= 1'b0;
      halted    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      reqRead   <= 1'b0;
      toCnt     <= '0;
      out_icode <= '0;
      out_valE  <= '0;
      valM      <= '0;
      stat      <= SAOK;
    end else begin
      state   <= stateNext;
      started <= 1'b1;
      case (state)
        S_IDLE: if (accept) begin
          out_icode <= icode;
          out_valE  <= valE;
          mem_we    <= isWrite;
          mem_addr  <= accAddr;
          mem_wdata <= accData;
          reqRead   <= isRead;
          // Loaded so it reads zero during the TIMEOUT-th cycle after issue.
          toCnt     <= CNT_W'(TIMEOUT - 1);
          valM      <= '0;
          if (!needMem) stat <= inStat;
        end
        S_REQ: begin
          if (toCnt != '0) toCnt <= toCnt - CNT_W'(1);
          if (!mem_gnt && toCnt == '0) stat <= SADR;
        end
        S_WAIT: begin
          if (toCnt != '0) toCnt <= toCnt - CNT_W'(1);
          if (mem_rvalid) begin
            stat <= mem_err ? SADR : SAOK;
            valM <= (reqRead && !mem_err) ? mem_rdata : '0;
          end else if (toCnt == '0) begin
            stat <= SADR;
            valM <= '0;
          end
        end
        S_DONE: if (out_ready && stat != SAOK) halted <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomised scoreboard bench for mem_stage_ctrl: stimulus predicts each result
// from the instruction rules and memory timing, a monitor checks delivered results.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT   = 15;
  localparam int MEM_BYTES = 8192;

  typedef struct packed {
    logic [3:0]  ic;
    logic [63:0] vE;
    logic [63:0] vM;
    logic [2:0]  st;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        instr_valid, imem_error;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [63:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [3:0]  out_icode;
  logic [63:0] out_valE, valM;
  logic [2:0]  stat;

  int   nCmp = 0;
  int   nBad = 0;
  exp_t q[$];
  int   doneCnt = 0;
  bit   expectReq = 0;
  bit   stallReq = 0;

  mem_stage_ctrl #(
    .DATA_W(64), .ADDR_W(64), .MEM_BYTES(MEM_BYTES), .ALIGN_CHK(1'b1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .valE(valE), .valA(valA), .valP(valP),
    .instr_valid(instr_valid), .imem_error(imem_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_valE(out_valE), .valM(valM), .stat(stat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: stat/valM from the priority rules and the memory's response time.
  function automatic exp_t predict(input logic [3:0] ic, input logic [63:0] vE, vA, vP,
                                   input bit iv, ie, input int g, lat,
                                   input logic [63:0] rd, input bit err,
                                   output bit goesMem, output bit isWr,
                                   output logic [63:0] addr, output logic [63:0] wdata);
    exp_t e;
    bit isRd, legal;
    isRd    = ic inside {4'h5, 4'h9, 4'hB};
    isWr    = ic inside {4'h4, 4'h8, 4'hA};
    addr    = (ic == 4'h9 || ic == 4'hB) ? vA : vE;
    wdata   = (ic == 4'h8) ? vP : vA;
    legal   = (addr <= 64'(MEM_BYTES - 8)) && (addr % 8 == 0);
    goesMem = 0;
    e.ic = ic; e.vE = vE; e.vM = '0;
    if (ie)                          e.st = 3'd3;
    else if (!iv)                    e.st = 3'd4;
    else if (ic == 4'h0)             e.st = 3'd2;
    else if ((isRd || isWr) && !legal) e.st = 3'd3;
    else if (isRd || isWr) begin
      goesMem = 1;
      if (g + 1 + lat > TIMEOUT) e.st = 3'd3;
      else if (err)              e.st = 3'd3;
      else begin
        e.st = 3'd1;
        if (isRd) e.vM = rd;
      end
    end else                         e.st = 3'd1;
    return e;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_valM", valM, 0);
    check("rst_stat", stat, 1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);
  endtask

  task automatic present(input logic [3:0] ic, input logic [63:0] vE, vA, vP, input bit iv, ie);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    icode = ic; valE = vE; valA = vA; valP = vP; instr_valid = iv; imem_error = ie;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic doTxn(input logic [3:0] ic, input logic [63:0] vE, vA, vP,
                       input bit iv, ie, input int g, lat,
                       input logic [63:0] rd, input bit err, input bit stall);
    exp_t e;
    bit goesMem, isWr;
    logic [63:0] addr, wdata;
    int prev, n;
    e = predict(ic, vE, vA, vP, iv, ie, g, lat, rd, err, goesMem, isWr, addr, wdata);
    q.push_back(e);
    prev = doneCnt;
    stallReq = stall;
    expectReq = goesMem;
    present(ic, vE, vA, vP, iv, ie);
    if (goesMem) begin
      check("req_issued", mem_req, 1);
      check("req_we", mem_we, isWr);
      check("req_addr", mem_addr, addr);
      if (isWr) check("req_wdata", mem_wdata, wdata);
      mem_gnt = 0;
      repeat (g) @(negedge clk);
      check("req_held", mem_req, 1);
      mem_gnt = 1;
      @(negedge clk);
      mem_gnt = 0;
      repeat (lat - 1) @(negedge clk);
      mem_rvalid = 1; mem_rdata = rd; mem_err = err;
      @(negedge clk);
      mem_rvalid = 0; mem_err = 0; mem_rdata = $urandom;
      expectReq = 0;
    end
    n = 0;
    while (doneCnt == prev && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (doneCnt == prev) check("result_delivered", doneCnt, prev + 1);
    stallReq = 0;
    if (e.st != 3'd1) begin
      icode = 4'h1; instr_valid = 1; imem_error = 0; in_valid = 1;
      repeat (4) begin
        @(negedge clk);
        check("halt_in_ready", in_ready, 0);
      end
      in_valid = 0;
      check("halt_stat_hold", stat, e.st);
      doReset();
    end
  endtask

  function automatic logic [63:0] randAddr();
    case ($urandom_range(0, 9))
      0:       return 64'($urandom_range(0, 1023)) * 8 + 64'($urandom_range(1, 7));
      1:       return 64'h1FF8;
      2:       return 64'h2000;
      3:       return {$urandom, $urandom} | 64'hFFFF_0000_0000_0000;
      default: return 64'($urandom_range(0, 1023)) * 8;
    endcase
  endfunction

  // Monitor: checks every presented result against the queue head and drives out_ready.
  initial begin
    int stallSeen = 0;
    exp_t e;
    out_ready = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!expectReq) check("stray_mem_req", mem_req, 0);
        if (out_valid) begin
          if (q.size() == 0) begin
            check("out_valid_spurious", out_valid, 0);
            out_ready = 1;
          end else begin
            e = q[0];
            check("out_icode", out_icode, e.ic);
            check("out_valE", out_valE, e.vE);
            check("valM", valM, e.vM);
            check("stat", stat, e.st);
            if (stallReq && stallSeen < 4) begin
              out_ready = 0;
              stallSeen++;
            end else out_ready = ($urandom_range(0, 3) != 0);
            if (out_ready) begin
              void'(q.pop_front());
              doneCnt++;
            end
          end
        end else begin
          out_ready = $urandom_range(0, 1);
          if (!stallReq) stallSeen = 0;
        end
      end else stallSeen = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; in_valid = 0; icode = 0; valE = 0; valA = 0; valP = 0;
    instr_valid = 1; imem_error = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
    #12;
    check("init_in_ready", in_ready, 0);
    check("init_mem_req", mem_req, 0);
    check("init_out_valid", out_valid, 0);
    check("init_valM", valM, 0);
    check("init_stat", stat, 1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("first_in_ready", in_ready, 1);

    doTxn(4'h5, 64'h100, 64'h0, 64'h0, 1, 0, 0, 3, 64'hDEAD, 0, 0);
    doTxn(4'h4, 64'h1FF8, 64'h55, 64'h0, 1, 0, 1, 2, 64'h0, 0, 0);
    doTxn(4'h5, 64'h200, 64'h0, 64'h0, 1, 0, 0, 14, 64'h1234, 0, 0);
    doTxn(4'h8, 64'h1F00, 64'h1, 64'hABCD, 1, 0, 2, 1, 64'h0, 0, 0);
    doTxn(4'h5, 64'h300, 64'h0, 64'h0, 1, 0, 1, 2, 64'h7777, 0, 1);
    doTxn(4'h6, 64'h5555, 64'h9, 64'h0, 1, 0, 0, 1, 64'h0, 0, 0);
    doTxn(4'h4, 64'h1FFC, 64'h55, 64'h0, 1, 0, 0, 1, 64'h0, 0, 0);
    doTxn(4'h0, 64'h0, 64'h0, 64'h0, 1, 0, 0, 1, 64'h0, 0, 0);
    doTxn(4'hB, 64'h0, 64'h80, 64'h0, 1, 0, 0, 18, 64'hBEEF, 0, 0);
    doTxn(4'h5, 64'h400, 64'h0, 64'h0, 1, 0, 0, 15, 64'hCAFE, 0, 0);
    doTxn(4'h5, 64'h100, 64'h0, 64'h0, 0, 1, 0, 1, 64'h0, 0, 0);
    doTxn(4'h5, 64'h100, 64'h0, 64'h0, 0, 0, 0, 1, 64'h0, 0, 0);
    doTxn(4'h9, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1, 0, 0, 1, 64'h0, 0, 0);
    doTxn(4'hA, 64'h800, 64'h42, 64'h0, 1, 0, 0, 2, 64'h0, 1, 0);

    // Reset while the request is outstanding.
    expectReq = 1;
    present(4'h5, 64'h200, 64'h0, 64'h0, 1, 0);
    check("midreq_mem_req", mem_req, 1);
    #2 rst_n = 0;
    #1;
    check("midreq_rst_mem_req", mem_req, 0);
    check("midreq_rst_out_valid", out_valid, 0);
    check("midreq_rst_stat", stat, 1);
    @(negedge clk);
    rst_n = 1;
    expectReq = 0;
    @(negedge clk);
    check("midreq_in_ready", in_ready, 1);

    for (int t = 0; t < 150; t++) begin
      logic [3:0]  ic;
      logic [63:0] vA;
      int          lat;
      ic  = 4'($urandom_range(0, 15));
      vA  = (ic == 4'h9 || ic == 4'hB) ? randAddr() : {$urandom, $urandom};
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 18) : $urandom_range(1, 6);
      doTxn(ic, randAddr(), vA, {$urandom, $urandom},
            $urandom_range(0, 19) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 2), lat, {$urandom, $urandom},
            $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
